// File: rtl/decode_execute_reg.sv
// Decode->Execute pipeline register with hold/flush/stall bubble insertion.
// Optional perf counters are built in when DE_PERF_CNT_EN is defined.
module decode_execute_reg #(
  parameter int XLEN       = 32,
  parameter int ALU_CTRL_W = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hold,
  input  logic                  stall,
  input  logic                  flush_e,
  input  logic                  valid_d,
  input  logic [4:0]            rs1_d,
  input  logic [4:0]            rs2_d,
  input  logic [4:0]            rd_d,
  input  logic [XLEN-1:0]       rd1_d,
  input  logic [XLEN-1:0]       rd2_d,
  input  logic [XLEN-1:0]       imm_ext_d,
  input  logic [XLEN-1:0]       pc_d,
  input  logic [XLEN-1:0]       pc_plus4_d,
  input  logic                  reg_write_d,
  input  logic                  mem_write_d,
  input  logic                  mem_read_d,
  input  logic                  jump_d,
  input  logic                  branch_d,
  input  logic                  alu_src_d,
  input  logic [1:0]            result_src_d,
  input  logic [ALU_CTRL_W-1:0] alu_control_d,
  output logic                  valid_e,
  output logic [4:0]            rs1_e,
  output logic [4:0]            rs2_e,
  output logic [4:0]            rd_e,
  output logic [XLEN-1:0]       rd1_e,
  output logic [XLEN-1:0]       rd2_e,
  output logic [XLEN-1:0]       imm_ext_e,
  output logic [XLEN-1:0]       pc_e,
  output logic [XLEN-1:0]       pc_plus4_e,
  output logic                  reg_write_e,
  output logic                  mem_write_e,
  output logic                  mem_read_e,
  output logic                  jump_e,
  output logic                  branch_e,
  output logic                  alu_src_e,
  output logic [1:0]            result_src_e,
  output logic [ALU_CTRL_W-1:0] alu_control_e,
  output logic                  en_fd
`ifdef DE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      bubble_cnt,
  output logic [CNT_W-1:0]      flush_cnt
`endif
);

  typedef struct packed {
    logic                  valid;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [XLEN-1:0]       rd1;
    logic [XLEN-1:0]       rd2;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       pc_plus4;
    logic                  reg_write;
    logic                  mem_write;
    logic                  mem_read;
    logic                  jump;
    logic                  branch;
    logic                  alu_src;
    logic [1:0]            result_src;
    logic [ALU_CTRL_W-1:0] alu_control;
  } ex_t;

  ex_t ex_q, ex_d, ex_load;

  always_comb begin
    ex_load             = '0;
    ex_load.valid       = valid_d;
    ex_load.rd1         = rd1_d;
    ex_load.rd2         = rd2_d;
    ex_load.imm         = imm_ext_d;
    ex_load.pc          = pc_d;
    ex_load.pc_plus4    = pc_plus4_d;
    // An invalid slot keeps pc/data but carries no indices or controls,
    // so it can never trigger a write, forward or load-use stall.
    if (valid_d) begin
      ex_load.rs1         = rs1_d;
      ex_load.rs2         = rs2_d;
      ex_load.rd          = rd_d;
      ex_load.reg_write   = reg_write_d;
      ex_load.mem_write   = mem_write_d;
      ex_load.mem_read    = mem_read_d;
      ex_load.jump        = jump_d;
      ex_load.branch      = branch_d;
      ex_load.alu_src     = alu_src_d;
      ex_load.result_src  = result_src_d;
      ex_load.alu_control = alu_control_d;
    end

    ex_d = ex_q;
    if (hold) begin
      ex_d = ex_q;
    end else if (flush_e || stall) begin
      ex_d = '0;
    end else begin
      ex_d = ex_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // Flush overrides stall: F/D must advance to fetch the branch target.
  assign en_fd = ~hold & (flush_e | ~stall);

  assign valid_e       = ex_q.valid;
  assign rs1_e         = ex_q.rs1;
  assign rs2_e         = ex_q.rs2;
  assign rd_e          = ex_q.rd;
  assign rd1_e         = ex_q.rd1;
  assign rd2_e         = ex_q.rd2;
  assign imm_ext_e     = ex_q.imm;
  assign pc_e          = ex_q.pc;
  assign pc_plus4_e    = ex_q.pc_plus4;
  assign reg_write_e   = ex_q.reg_write;
  assign mem_write_e   = ex_q.mem_write;
  assign mem_read_e    = ex_q.mem_read;
  assign jump_e        = ex_q.jump;
  assign branch_e      = ex_q.branch;
  assign alu_src_e     = ex_q.alu_src;
  assign result_src_e  = ex_q.result_src;
  assign alu_control_e = ex_q.alu_control;

`ifdef DE_PERF_CNT_EN
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (!hold && stall && !flush_e && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
    if (!hold && flush_e && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_decode_execute_reg.sv
// Scoreboard bench for decode_execute_reg: driver pushes model expectations,
// monitor compares one cycle later. Honours DE_PERF_CNT_EN when defined.
module tb_decode_execute_reg;
  localparam int XLEN  = 32;
  localparam int ACW   = 4;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic hold, stall, flush, valid;
    logic [4:0] rs1, rs2, rd;
    logic [XLEN-1:0] rd1, rd2, imm, pc, pc4;
    logic rw, mw, mr, j, b, as;
    logic [1:0] rsrc;
    logic [ACW-1:0] alu;
  } in_t;

  typedef struct packed {
    logic valid;
    logic [4:0] rs1, rs2, rd;
    logic [XLEN-1:0] rd1, rd2, imm, pc, pc4;
    logic rw, mw, mr, j, b, as;
    logic [1:0] rsrc;
    logic [ACW-1:0] alu;
  } ex_t;

  typedef struct {
    ex_t e;
    int  bub;
    int  fl;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic hold, stall, flush_e, valid_d;
  logic [4:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e;
  logic [XLEN-1:0] rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d;
  logic [XLEN-1:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
  logic reg_write_d, mem_write_d, mem_read_d, jump_d, branch_d, alu_src_d;
  logic valid_e, reg_write_e, mem_write_e, mem_read_e, jump_e, branch_e, alu_src_e;
  logic [1:0] result_src_d, result_src_e;
  logic [ACW-1:0] alu_control_d, alu_control_e;
  logic en_fd;
`ifdef DE_PERF_CNT_EN
  logic [CNT_W-1:0] bubble_cnt, flush_cnt;
`endif

  int checks = 0;
  int failures = 0;
  exp_t q[$];
  ex_t m_e;
  int m_bub, m_fl;
  localparam int CMAX = (1 << CNT_W) - 1;

  always #5 clk = ~clk;

  decode_execute_reg #(.XLEN(XLEN), .ALU_CTRL_W(ACW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .stall(stall), .flush_e(flush_e),
    .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_ext_d(imm_ext_d), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d), .reg_write_d(reg_write_d), .mem_write_d(mem_write_d),
    .mem_read_d(mem_read_d), .jump_d(jump_d), .branch_d(branch_d),
    .alu_src_d(alu_src_d), .result_src_d(result_src_d), .alu_control_d(alu_control_d),
    .valid_e(valid_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e), .pc_e(pc_e),
    .pc_plus4_e(pc_plus4_e), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
    .mem_read_e(mem_read_e), .jump_e(jump_e), .branch_e(branch_e),
    .alu_src_e(alu_src_e), .result_src_e(result_src_e), .alu_control_e(alu_control_e),
    .en_fd(en_fd)
`ifdef DE_PERF_CNT_EN
    , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  function automatic ex_t actual();
    ex_t a;
    a = '{valid_e, rs1_e, rs2_e, rd_e, rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e,
          reg_write_e, mem_write_e, mem_read_e, jump_e, branch_e, alu_src_e,
          result_src_e, alu_control_e};
    return a;
  endfunction

  function automatic in_t rand_in();
    in_t x;
    x.hold  = ($urandom_range(7) == 0);
    x.stall = ($urandom_range(5) == 0);
    x.flush = ($urandom_range(7) == 0);
    x.valid = ($urandom_range(4) != 0);
    x.rs1 = 5'($urandom); x.rs2 = 5'($urandom); x.rd = 5'($urandom);
    x.rd1 = $urandom; x.rd2 = $urandom; x.imm = $urandom;
    x.pc  = $urandom; x.pc4 = x.pc + 32'd4;
    x.rw = 1'($urandom); x.mw = 1'($urandom); x.mr = 1'($urandom);
    x.j = 1'($urandom); x.b = 1'($urandom); x.as = 1'($urandom);
    x.rsrc = 2'($urandom); x.alu = ACW'($urandom);
    return x;
  endfunction

  // Reference behaviour: what E should hold after this edge.
  function automatic ex_t model_next(ex_t cur, in_t x);
    ex_t n;
    if (x.hold) return cur;
    if (x.flush || x.stall) return '0;
    n = '0;
    n.valid = x.valid;
    n.rd1 = x.rd1; n.rd2 = x.rd2; n.imm = x.imm; n.pc = x.pc; n.pc4 = x.pc4;
    if (x.valid) begin
      n.rs1 = x.rs1; n.rs2 = x.rs2; n.rd = x.rd;
      n.rw = x.rw; n.mw = x.mw; n.mr = x.mr; n.j = x.j; n.b = x.b; n.as = x.as;
      n.rsrc = x.rsrc; n.alu = x.alu;
    end
    return n;
  endfunction

  task automatic apply(in_t x);
    hold = x.hold; stall = x.stall; flush_e = x.flush; valid_d = x.valid;
    rs1_d = x.rs1; rs2_d = x.rs2; rd_d = x.rd;
    rd1_d = x.rd1; rd2_d = x.rd2; imm_ext_d = x.imm; pc_d = x.pc; pc_plus4_d = x.pc4;
    reg_write_d = x.rw; mem_write_d = x.mw; mem_read_d = x.mr;
    jump_d = x.j; branch_d = x.b; alu_src_d = x.as;
    result_src_d = x.rsrc; alu_control_d = x.alu;
  endtask

  task automatic cycle(in_t x);
    exp_t ex;
    logic en_exp;
    @(negedge clk);
    apply(x);
    #1;
    en_exp = !x.hold && (x.flush || !x.stall);
    checks++;
    if (en_fd !== en_exp) begin
      failures++;
      $display("FAIL en_fd actual=%b required=%b (hold=%b stall=%b flush=%b)",
               en_fd, en_exp, x.hold, x.stall, x.flush);
    end
    m_e = model_next(m_e, x);
    if (!x.hold && x.stall && !x.flush && m_bub < CMAX) m_bub++;
    if (!x.hold && x.flush && m_fl < CMAX) m_fl++;
    ex.e = m_e; ex.bub = m_bub; ex.fl = m_fl;
    q.push_back(ex);
  endtask

  // Monitor: the register presents a new E state every cycle.
  initial begin
    exp_t ex;
    ex_t a;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        ex = q.pop_front();
        a = actual();
        checks++;
        if (a !== ex.e) begin
          failures++;
          $display("FAIL e_regs actual=%h required=%h", a, ex.e);
        end
`ifdef DE_PERF_CNT_EN
        checks++;
        if (bubble_cnt !== CNT_W'(ex.bub) || flush_cnt !== CNT_W'(ex.fl)) begin
          failures++;
          $display("FAIL perf_cnt actual bub=%0d fl=%0d required bub=%0d fl=%0d",
                   bubble_cnt, flush_cnt, ex.bub, ex.fl);
        end
`endif
      end
    end
  end

  task automatic check_reset(string name);
    checks++;
    if (actual() !== ex_t'('0)) begin
      failures++;
      $display("FAIL %s actual=%h required=0", name, actual());
    end
`ifdef DE_PERF_CNT_EN
    checks++;
    if (bubble_cnt !== '0 || flush_cnt !== '0) begin
      failures++;
      $display("FAIL %s_cnt actual bub=%0d fl=%0d required 0", name, bubble_cnt, flush_cnt);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t x;
    rst_n = 1'b0;
    apply(rand_in());
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    m_e = '0; m_bub = 0; m_fl = 0;

    // Normal load
    x = rand_in(); x.hold = 0; x.stall = 0; x.flush = 0; x.valid = 1;
    x.rd = 5'd5; x.rd1 = 32'h1234; x.rw = 1;
    cycle(x);
    // Load-use stall then release with the same D instruction
    x = rand_in(); x.hold = 0; x.stall = 1; x.flush = 0; x.valid = 1; x.rd = 5'd7; x.mr = 1;
    cycle(x);
    x.stall = 0;
    cycle(x);
    // Flush and stall together
    x = rand_in(); x.hold = 0; x.stall = 1; x.flush = 1; x.valid = 1;
    cycle(x);
    // Load rd=3, hold for 3 cycles with flush pending, then release
    x = rand_in(); x.hold = 0; x.stall = 0; x.flush = 0; x.valid = 1; x.rd = 5'd3;
    cycle(x);
    for (int i = 0; i < 3; i++) begin
      x = rand_in(); x.hold = 1; x.flush = 1;
      cycle(x);
    end
    x = rand_in(); x.hold = 0; x.flush = 1;
    cycle(x);
    // Invalid slot is loaded with controls stripped
    x = rand_in(); x.hold = 0; x.stall = 0; x.flush = 0; x.valid = 0;
    x.rw = 1; x.mr = 1; x.rd = 5'd9;
    cycle(x);
    // Long stall run drives bubble counter to saturation
    for (int i = 0; i < 20; i++) begin
      x = rand_in(); x.hold = 0; x.stall = 1; x.flush = 0;
      cycle(x);
    end
    // Randomized traffic
    for (int i = 0; i < 300; i++) cycle(rand_in());

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset("async_reset");
    rst_n = 1'b1;
    m_e = '0; m_bub = 0; m_fl = 0;
    x = rand_in(); x.hold = 0; x.stall = 0; x.flush = 0; x.valid = 1;
    cycle(x);
    for (int i = 0; i < 60; i++) cycle(rand_in());

    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0 pending", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
